// File: rtl/rv_core_pkg.sv
// Shared types and constants for the instruction fetch path.
package rv_core_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RV_NOP      = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // A fetch target is illegal if not word aligned or beyond the fetchable space.
  function automatic logic pc_is_bad(input logic [31:0] addr, input logic [31:0] limit);
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO with flush; head is driven straight from storage.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;

  // When full, wr_ptr == rd_ptr, so a simultaneous pop+push overwrites the
  // slot being vacated and it becomes the new tail, preserving order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, boot/run/fault FSM, next-PC mux and a
// 2-entry output buffer toward decode.
module instr_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IMEM_BYTES = 32'd64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [1:0]   count;
  logic [63:0]  head;
  logic         in_run;
  logic         pop;
  logic         fetch;
  logic         seq_bad;
  logic         target_bad;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_flush;

  assign pc_plus4   = pc + INSTR_BYTES;
  assign seq_bad    = pc_is_bad(pc_plus4, IMEM_BYTES);
  assign target_bad = pc_is_bad(redirect_target, IMEM_BYTES);
  assign in_run     = (state == RUN);

  assign out_valid  = (count != 2'd0);
  assign pop        = out_valid && out_ready;
  assign fetch      = in_run && !redirect_valid && ((count != 2'd2) || pop);

  // A redirect or a faulting fetch discards everything buffered this cycle.
  assign fifo_flush = in_run && (redirect_valid || (fetch && seq_bad));
  assign fifo_push  = fetch && !seq_bad;
  assign fifo_pop   = pop && !fifo_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redirect_valid) begin
            pc <= redirect_target;
            if (target_bad) begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end else if (fetch) begin
            pc <= pc_plus4;
            if (seq_bad) begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end
        end
        FAULT: state <= FAULT;
        default: state <= BOOT;
      endcase
    end
  end

  fetch_fifo #(.WIDTH(64)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .data_in ({imem_rdata, pc}),
    .count   (count),
    .head    (head)
  );

  assign imem_addr    = pc;
  assign out_instr    = head[63:32];
  assign out_pc       = head[31:0];
  assign out_pc_plus4 = out_pc + INSTR_BYTES;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory word at address k is 32'h1000_0000+k.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fault;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign imem_rdata = 32'h1000_0000 + imem_addr;

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pc_plus4    (out_pc_plus4),
    .fault           (fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns in cycle 0 (BOOT) with reset just released.
  task automatic start_run();
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    out_ready       = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    out_ready       = 1'b1;
    repeat (2) step();

    chk("rst_addr",   imem_addr,           32'h0);
    chk("rst_valid",  32'(out_valid),      32'h0);
    chk("rst_fault",  32'(fault),          32'h0);
    chk("rst_instr",  out_instr,           32'h0);
    chk("rst_pc",     out_pc,              32'h0);
    chk("rst_plus4",  out_pc_plus4,        32'h4);

    // Sequential stream, out_ready held high
    reset = 1'b0;
    chk("boot_valid", 32'(out_valid), 32'h0);
    step();
    chk("c1_valid", 32'(out_valid), 32'h0);
    chk("c1_addr",  imem_addr,      32'h0);
    step();
    chk("c2_valid", 32'(out_valid), 32'h1);
    chk("c2_pc",    out_pc,         32'h0);
    chk("c2_instr", out_instr,      32'h1000_0000);
    chk("c2_plus4", out_pc_plus4,   32'h4);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("seq_valid", 32'(out_valid), 32'h1);
      chk("seq_pc",    out_pc,         32'(4 * k));
      chk("seq_instr", out_instr,      32'h1000_0000 + 32'(4 * k));
      chk("seq_plus4", out_pc_plus4,   32'(4 * k + 4));
    end

    // Backpressure for cycles 2..6, release in cycle 7
    start_run();
    step();
    step();
    chk("bp_first", out_pc, 32'h0);
    out_ready = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      step();
      chk("bp_hold_addr", imem_addr,      32'h8);
      chk("bp_hold_pc",   out_pc,         32'h0);
      chk("bp_hold_vld",  32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("bp_drain_pc", out_pc, 32'(4 * k));
    end
    chk("bp_drain_addr", imem_addr, 32'h14);

    // Redirect to 0x20 while holding pc 4 and 8
    start_run();
    step();
    step();
    out_ready = 1'b0;
    repeat (5) step();
    out_ready = 1'b1;
    step();
    chk("rd_pre_pc", out_pc, 32'h4);
    redirect_valid  = 1'b1;
    redirect_target = 32'h20;
    step();
    redirect_valid = 1'b0;
    chk("rd_n1_valid", 32'(out_valid), 32'h0);
    chk("rd_n1_addr",  imem_addr,      32'h20);
    step();
    chk("rd_n2_valid", 32'(out_valid), 32'h1);
    chk("rd_n2_pc",    out_pc,         32'h20);
    chk("rd_n2_instr", out_instr,      32'h1000_0020);
    step();
    chk("rd_n3_pc",    out_pc,         32'h24);

    // Misaligned redirect, then an ignored redirect while faulted
    redirect_valid  = 1'b1;
    redirect_target = 32'h22;
    step();
    chk("mis_fault", 32'(fault),     32'h1);
    chk("mis_valid", 32'(out_valid), 32'h0);
    chk("mis_addr",  imem_addr,      32'h22);
    redirect_target = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("mis_ign_fault", 32'(fault),     32'h1);
    chk("mis_ign_addr",  imem_addr,      32'h22);
    chk("mis_ign_valid", 32'(out_valid), 32'h0);

    // Run off the end of memory from 56
    start_run();
    step();
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h38;
    step();
    redirect_valid = 1'b0;
    chk("end_addr56",  imem_addr,      32'h38);
    chk("end_vld0",    32'(out_valid), 32'h0);
    step();
    chk("end_pc56",    out_pc,         32'h38);
    chk("end_instr56", out_instr,      32'h1000_0038);
    chk("end_addr60",  imem_addr,      32'h3c);
    chk("end_nofault", 32'(fault),     32'h0);
    step();
    chk("end_fault",   32'(fault),     32'h1);
    chk("end_vld",     32'(out_valid), 32'h0);
    chk("end_addr64",  imem_addr,      32'h40);
    #2 reset = 1'b1;
    #1;
    chk("async_fault", 32'(fault),     32'h0);
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_addr",  imem_addr,      32'h0);
    #1 reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
